// File: rtl/sp_rx_align.sv
// -----------------------------------------------------------------------------
// sp_rx_align -- serial-to-parallel receiver with comma alignment
//
// Receives the 32f serial lane one bit per clk_32f rising edge, MSB of each
// byte first. The upstream serializer sends the idle comma (COMMA, 0xBC)
// until this block raises `active`, then it sends data bytes.
//
// Operation:
//   HUNT   : look for COMMA at any bit offset. A hit fixes the byte phase.
//   SYNC   : count boundary-aligned commas. One non-comma byte on a boundary
//            sends the receiver back to HUNT.
//   LOCKED : emit every byte on its boundary. Comma bytes update data_out
//            but do not pulse valid_out.
//
// Ports:
//   clk_32f        in   bit clock, one serial bit per rising edge
//   reset_L        in   asynchronous active-low reset
//   in_serial      in   serial data, MSB first
//   data_out       out  [7:0] last byte captured on a boundary while LOCKED
//   valid_out      out  one-cycle pulse, data_out holds a new non-comma byte
//   active         out  high while LOCKED
//   comma_cnt_out  out  [3:0] current aligned-comma count (debug)
//
// Parameters:
//   COMMA          idle / alignment byte (default 8'hBC)
//   LOCK_COUNT     aligned commas needed to lock, legal 1..15 (default 4)
//
// Optional build macro:
//   SP_RX_LOSS_OF_LOCK_EN
//     When defined, two misaligned commas seen while LOCKED with no
//     boundary-aligned comma between them drop the lock and restart HUNT.
//     When undefined, LOCKED is left only through reset_L.
// -----------------------------------------------------------------------------
module sp_rx_align #(
  parameter logic [7:0]  COMMA      = 8'hBC,
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset_L,
  input  logic       in_serial,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active,
  output logic [3:0] comma_cnt_out
);

  // Lock threshold at the width of the comma counter.
  localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t      r_state;
  logic [7:0]  r_sr;
  logic [2:0]  r_bit_cnt;
  logic [3:0]  r_comma_cnt;

  logic [7:0]  w_nxt;
  logic        w_is_comma;
  logic        w_boundary;
  logic [3:0]  w_cnt_inc;

  // The byte under test includes the bit arriving on this edge, so a comma
  // is detected on the same edge that samples its last bit.
  assign w_nxt      = {r_sr[6:0], in_serial};
  assign w_is_comma = (w_nxt == COMMA);
  assign w_boundary = (r_bit_cnt == 3'd7);
  // Only used in SYNC, where r_comma_cnt < LOCK_CNT <= 15, so no overflow.
  assign w_cnt_inc  = r_comma_cnt + 4'd1;

  assign comma_cnt_out = r_comma_cnt;

`ifdef SP_RX_LOSS_OF_LOCK_EN
  // Set by a misaligned comma while LOCKED; cleared by an aligned comma.
  logic r_misalign;
`endif

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others; the reset branch is
  // in the sensitivity list so reset_L acts without waiting for a clock.
  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      r_state     <= ST_HUNT;
      r_sr        <= 8'h00;
      r_bit_cnt   <= 3'd0;
      r_comma_cnt <= 4'd0;
      data_out    <= 8'h00;
      valid_out   <= 1'b0;
      active      <= 1'b0;
`ifdef SP_RX_LOSS_OF_LOCK_EN
      r_misalign  <= 1'b0;
`endif
    end else begin
      r_sr      <= w_nxt;
      valid_out <= 1'b0;

      case (r_state)
        // ---------------------------------------------------------------
        // Bit phase is unknown: accept a comma at any offset. The comma
        // hit closes a byte, so the next byte starts counting from 0.
        // ---------------------------------------------------------------
        ST_HUNT: begin
          r_bit_cnt <= 3'd0;
          if (w_is_comma) begin
            r_comma_cnt <= 4'd1;
            if (LOCK_CNT == 4'd1) begin
              r_state <= ST_LOCKED;
              active  <= 1'b1;
            end else begin
              r_state <= ST_SYNC;
            end
          end
        end

        // ---------------------------------------------------------------
        // Phase is fixed; only boundary bytes are examined. Any
        // non-comma boundary byte means the first hit was a false match.
        // ---------------------------------------------------------------
        ST_SYNC: begin
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (w_boundary) begin
            if (w_is_comma) begin
              r_comma_cnt <= w_cnt_inc;
              if (w_cnt_inc == LOCK_CNT) begin
                r_state <= ST_LOCKED;
                active  <= 1'b1;
              end
            end else begin
              r_comma_cnt <= 4'd0;
              r_state     <= ST_HUNT;
            end
          end
        end

        // ---------------------------------------------------------------
        // Deliver bytes. Commas are idle fill: they refresh data_out but
        // do not pulse valid_out. The comma count stays saturated.
        // ---------------------------------------------------------------
        ST_LOCKED: begin
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (w_boundary) begin
            data_out  <= w_nxt;
            valid_out <= !w_is_comma;
`ifdef SP_RX_LOSS_OF_LOCK_EN
            if (w_is_comma) begin
              r_misalign <= 1'b0;
            end
          end else if (w_is_comma) begin
            // Second misaligned comma without an aligned one in between:
            // the upstream phase has moved, so restart alignment.
            if (r_misalign) begin
              r_misalign  <= 1'b0;
              r_comma_cnt <= 4'd0;
              r_bit_cnt   <= 3'd0;
              active      <= 1'b0;
              r_state     <= ST_HUNT;
            end else begin
              r_misalign <= 1'b1;
            end
`endif
          end
        end

        default: begin
          r_state     <= ST_HUNT;
          r_bit_cnt   <= 3'd0;
          r_comma_cnt <= 4'd0;
          active      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/sp_rx_align.md
Name: sp_rx_align

Overview:
- Serial-to-parallel receiver for the 32f serial lane.
- Sits directly downstream of the RX-side parallel-to-serial stage, which emits idle comma 0xBC while inactive and data bytes once active.
- Hunts for the 0xBC comma at any bit offset, locks byte alignment after a run of aligned commas, then deserializes bytes MSB-first.
- Drives `active` back to the upstream serializer.

Parameters:
- COMMA, 8'hBC, idle/alignment byte.
- LOCK_COUNT, 4, consecutive boundary-aligned commas required to assert active (legal 1..15).

Ports:
- clk_32f  input  1  bit clock; one serial bit per rising edge
- reset_L  input  1  asynchronous, active-low reset
- in_serial  input  1  serial data, MSB of each byte first
- data_out  output  8  deserialized data byte
- valid_out  output  1  one-cycle pulse: data_out holds a new non-comma byte
- active  output  1  high while in LOCKED
- comma_cnt_out  output  4  current aligned-comma count (debug)

Behaviour:
- Clocking and reset:
  - All state updates on posedge clk_32f.
  - reset_L low asynchronously forces: state=HUNT, shift register=0, bit_cnt=0, comma_cnt=0, data_out=8'h00, valid_out=0, active=0, comma_cnt_out=0.
  - Reset asserted mid-byte or mid-lock discards the partial byte. Hunting restarts from the first edge after release.
- Shift and comparison:
  - sr <= {sr[6:0], in_serial} every cycle.
  - nxt = {sr[6:0], in_serial} is the value compared this cycle.
- Bit counter: bit_cnt is 3 bits and wraps 7->0. A byte boundary is any cycle with bit_cnt==7.
- State HUNT:
  - bit_cnt ignored.
  - If nxt==COMMA: bit_cnt<=0, comma_cnt<=1, go to SYNC. This cycle ends the byte.
  - A comma found at any of the 8 offsets is accepted.
- State SYNC:
  - bit_cnt increments each cycle.
  - At a boundary with nxt==COMMA: comma_cnt+1. If comma_cnt+1==LOCK_COUNT, go to LOCKED and set active<=1 on the same edge.
  - At a boundary with nxt!=COMMA: comma_cnt<=0, go to HUNT.
  - With LOCK_COUNT==1, go to LOCKED directly from HUNT on the first comma.
- State LOCKED:
  - At each boundary: data_out<=nxt.
  - valid_out<=1 for exactly one cycle if nxt!=COMMA. A comma byte updates data_out but keeps valid_out=0 (idle fill).
  - Non-boundary cycles: valid_out=0, data_out holds its value.
  - Remains LOCKED until reset (default build).
- Latency:
  - Byte bits b7..b0 are sampled on edges k..k+7.
  - data_out/valid_out are visible after edge k+7, so latency is 0 cycles past the last bit.
  - active rises on the edge that samples the final bit of the LOCK_COUNT-th aligned comma.
- comma_cnt saturates at LOCK_COUNT. comma_cnt_out mirrors comma_cnt.
- In HUNT/SYNC: valid_out=0 and data_out is not updated.

Optional Feature:
- Macro SP_RX_LOSS_OF_LOCK_EN.
- When defined, in LOCKED:
  - A cycle with nxt==COMMA and bit_cnt!=7 marks a misaligned comma.
  - Two misaligned commas with no intervening boundary-aligned comma cause the following on the second one's edge: active<=0, comma_cnt<=0, go to HUNT, valid_out<=0.
  - An aligned comma clears the misalign flag.
- When undefined: no misalign tracking; LOCKED exits only via reset_L.

Test Plan:
- Reset then 5x 0xBC aligned from edge 0 -> active rises at edge 31 (4th comma end); comma_cnt_out 1,2,3,4; valid_out stays 0.
- 3 random bits, then 6x 0xBC -> comma found at offset 3; active high after 4th aligned comma (edge 34); no valid_out pulses.
- Locked, send 0x7C, 0x00, 0xFF, 0xBC, 0xA5 -> valid_out pulses with data_out 0x7C, 0x00, 0xFF, then none for 0xBC (data_out=0xBC), then pulse with 0xA5; each pulse on the 8th bit edge.
- In SYNC after 2 commas, send 0x3C -> comma_cnt_out=0, state HUNT, active stays 0; then 4x 0xBC -> lock.
- reset_L pulsed low mid-byte while LOCKED (asynchronous, between edges) -> all outputs 0 immediately; re-lock needs LOCK_COUNT commas.
- With SP_RX_LOSS_OF_LOCK_EN: locked, shift the stream by 1 bit carrying 0xBC twice -> active drops at the second misaligned comma; without the macro, active stays 1.
